// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage.
// Data wins by default; a burst limiter guarantees fetch progress and a timeout aborts hung accesses.
module unified_mem_arbiter #(
    parameter int          MAX_D_BURST = 4,
    parameter int          TIMEOUT     = 64,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_ubhw,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_ubhw,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    state_t      state;
    logic [3:0]  burst;
    logic [7:0]  tmo_cnt;
    logic        grant_d;
    logic        grant_i;
    logic        finish;
    logic [31:0] done_data;

    // Handshake: if_req/d_req are held until their one-cycle ack; mem_req is held until mem_ack.
    assign grant_d   = d_req && !(if_req && burst == BURST_MAX);
    assign grant_i   = if_req && !grant_d;
    assign finish    = mem_ack || (tmo_cnt == TMO_LAST);
    assign done_data = mem_ack ? (mem_we ? 32'h0 : mem_rdata) : ERR_DATA;

    assign stall_if  = !rst && if_req && !if_ack;
    assign stall_mem = !rst && d_req && !d_ack;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst     <= 4'd0;
            tmo_cnt   <= 8'd0;
            bus_err   <= 1'b0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= 32'h0;
            d_rdata   <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_ubhw  <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= 8'd0;
                    if (grant_d) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_ubhw  <= d_ubhw;
                        // Only data grants that overtake a waiting fetch count towards the limit.
                        if (if_req)
                            burst <= (burst == BURST_MAX) ? burst : burst + 4'd1;
                        else
                            burst <= 4'd0;
                    end else if (grant_i) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= 32'h0;
                        mem_ubhw  <= 3'b010;
                        burst     <= 4'd0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (finish) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (!mem_ack)
                            bus_err <= 1'b1;
                        if (state == BUSY_I) begin
                            if_ack   <= 1'b1;
                            if_rdata <= done_data;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= done_data;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a transaction-level model checked every cycle,
// plus hand-computed expectations for latency, priority, burst limit, timeout and reset.
module tb_unified_mem_arbiter;
    localparam int          MAXB = 4;
    localparam int          TMO  = 64;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        if_req, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  d_ubhw;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_ubhw;
    logic        stall_if, stall_mem, bus_err;
    logic [1:0]  dbg_state;

    unified_mem_arbiter #(.MAX_D_BURST(MAXB), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ubhw(d_ubhw),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ubhw(mem_ubhw), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- backend memory ----------------
    logic [31:0] mem_arr [logic [31:0]];
    int          be_lat   = 1;
    int          be_cnt   = 0;
    logic        spurious = 1'b0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    // be_lat = cycles after mem_req rises before mem_ack; 0 means never answer.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (spurious) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h0BAD_0BAD;
                spurious  = 1'b0;
            end else if (mem_req && !rst) begin
                if (be_lat > 0 && be_cnt == be_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_word(mem_addr);
                    if (mem_we) mem_arr[mem_addr] = mem_wdata;
                end else begin
                    mem_ack = 1'b0;
                end
                be_cnt++;
            end else begin
                mem_ack = 1'b0;
                be_cnt  = 0;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    // who is being served (-1 none, 0 fetch, 1 data), who is being acked this cycle
    int          m_busy = -1;
    int          m_done = -1;
    int          m_wait = 0;
    int          m_burst = 0;
    logic        m_req = 1'b0, m_we = 1'b0, m_err = 1'b0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
    logic [2:0]  m_ubhw = 3'b000;
    logic [31:0] m_rdata [2] = '{32'h0, 32'h0};

    task automatic model_step();
        if (rst) begin
            m_busy = -1; m_done = -1; m_wait = 0; m_burst = 0;
            m_req = 1'b0; m_we = 1'b0; m_err = 1'b0;
            m_addr = 32'h0; m_wdata = 32'h0; m_ubhw = 3'b000;
            m_rdata[0] = 32'h0; m_rdata[1] = 32'h0;
        end else if (m_done != -1) begin
            m_done = -1;
        end else if (m_busy != -1) begin
            if (mem_ack || m_wait == TMO - 1) begin
                m_rdata[m_busy] = !mem_ack ? ERR : (m_we ? 32'h0 : mem_rdata);
                if (!mem_ack) m_err = 1'b1;
                m_done = m_busy;
                m_busy = -1;
                m_req  = 1'b0;
            end else begin
                m_wait++;
            end
        end else if (d_req && !(if_req && m_burst == MAXB)) begin
            m_busy = 1; m_wait = 0; m_req = 1'b1;
            m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_ubhw = d_ubhw;
            m_burst = if_req ? ((m_burst < MAXB) ? m_burst + 1 : MAXB) : 0;
        end else if (if_req) begin
            m_busy = 0; m_wait = 0; m_req = 1'b1;
            m_we = 1'b0; m_addr = if_addr; m_ubhw = 3'b010;
            m_burst = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic compare_all();
        logic e_iack, e_dack;
        e_iack = !rst && m_done == 0;
        e_dack = !rst && m_done == 1;
        check("mem_req",   mem_req,   rst ? 1'b0 : m_req);
        check("mem_we",    mem_we,    rst ? 1'b0 : m_we);
        check("mem_addr",  mem_addr,  rst ? 32'h0 : m_addr);
        if (!rst && m_req && m_we) check("mem_wdata", mem_wdata, m_wdata);
        check("mem_ubhw",  mem_ubhw,  rst ? 3'b000 : m_ubhw);
        check("if_ack",    if_ack,    e_iack);
        check("d_ack",     d_ack,     e_dack);
        check("if_rdata",  if_rdata,  rst ? 32'h0 : m_rdata[0]);
        check("d_rdata",   d_rdata,   rst ? 32'h0 : m_rdata[1]);
        check("stall_if",  stall_if,  !rst && if_req && !e_iack);
        check("stall_mem", stall_mem, !rst && d_req && !e_dack);
        check("bus_err",   bus_err,   rst ? 1'b0 : m_err);
    endtask

    // ---------------- compare process and monitors ----------------
    logic        cmp_en = 1'b0;
    logic        log_en = 1'b0;
    logic        prev_req = 1'b0;
    int          req_hi_cnt = 0;
    int          d_ack_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    initial forever begin
        @(negedge clk);
        if (cmp_en) compare_all();
        if (log_en && mem_req && !prev_req) got_q.push_back({31'h0, mem_addr[13]});
        if (mem_req) req_hi_cnt++;
        if (d_ack) d_ack_cnt++;
        prev_req = mem_req;
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; raises the request, waits for its ack, drops it after the ack cycle.
    task automatic do_req(input logic side_d, input logic [31:0] addr, input logic we,
                          input logic [31:0] wd, input logic [2:0] ub,
                          output int ack_t, output logic [31:0] rd);
        int n = 0;
        ack_t = -1;
        rd    = 32'h0;
        if (side_d) begin
            d_req = 1'b1; d_addr = addr; d_we = we; d_wdata = wd; d_ubhw = ub;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        while (ack_t < 0 && n < 300) begin
            @(negedge clk);
            n++;
            if (side_d ? d_ack : if_ack) begin
                ack_t = cyc;
                rd    = side_d ? d_rdata : if_rdata;
            end
        end
        if (ack_t < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_ack_wait: no ack within 300 cycles, required one", side_d ? "data" : "fetch");
        end
        @(posedge clk); #1;
        if (side_d) d_req = 1'b0; else if_req = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int          t_i, t_d, t_x;
        logic [31:0] r_i, r_d, r_x;

        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_ubhw = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_if_ack", if_ack, 1'b0);
        check("rst_d_ack", d_ack, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        cmp_en = 1'b1;

        // stray backend ack while idle must be ignored
        @(negedge clk) spurious = 1'b1;
        repeat (3) @(negedge clk);
        check("spur_mem_req", mem_req, 1'b0);
        check("spur_if_ack", if_ack, 1'b0);
        check("spur_d_rdata", d_rdata, 32'h0);

        // T1: single fetch, 1-cycle backend
        mem_arr[32'h40] = 32'h0050_0093;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        check("t1_c0_stall_if", stall_if, 1'b1);
        check("t1_c0_mem_req", mem_req, 1'b0);
        @(negedge clk);
        check("t1_c1_mem_req", mem_req, 1'b1);
        check("t1_c1_mem_addr", mem_addr, 32'h40);
        check("t1_c1_mem_ubhw", mem_ubhw, 3'b010);
        @(negedge clk);
        check("t1_c2_stall_if", stall_if, 1'b1);
        check("t1_c2_if_ack", if_ack, 1'b0);
        @(negedge clk);
        check("t1_c3_if_ack", if_ack, 1'b1);
        check("t1_c3_if_rdata", if_rdata, 32'h0050_0093);
        check("t1_c3_stall_if", stall_if, 1'b0);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        check("t1_c4_if_ack", if_ack, 1'b0);
        check("t1_c4_if_rdata_held", if_rdata, 32'h0050_0093);

        // T2: simultaneous requests, data store wins
        repeat (2) @(posedge clk); #1;
        fork
            do_req(1'b0, 32'h1040, 1'b0, 32'h0, 3'b010, t_i, r_i);
            do_req(1'b1, 32'h100, 1'b1, 32'h1234, 3'b010, t_d, r_d);
            begin
                repeat (2) @(negedge clk);
                check("t2_c1_mem_we", mem_we, 1'b1);
                check("t2_c1_mem_addr", mem_addr, 32'h100);
                check("t2_c1_mem_wdata", mem_wdata, 32'h1234);
            end
        join
        check("t2_d_before_i", {31'h0, t_d < t_i}, 32'h1);
        check("t2_store_rdata", r_d, 32'h0);
        check("t2_fetch_rdata", r_i, rd_word(32'h1040));

        // T3: burst limiter with a continuously waiting fetch
        repeat (2) @(posedge clk); #1;
        exp_q = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h0, 32'h1, 32'h1};
        got_q.delete();
        log_en = 1'b1;
        fork
            do_req(1'b0, 32'h1080, 1'b0, 32'h0, 3'b010, t_i, r_i);
            for (int i = 0; i < 6; i++)
                do_req(1'b1, 32'h2000 + 32'(4 * i), 1'b0, 32'h0, 3'b010, t_x, r_x);
        join
        log_en = 1'b0;
        check("t3_grant_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("t3_grant_%0d", i), got_q[i], exp_q[i]);

        // T4: hung backend
        repeat (2) @(posedge clk); #1;
        be_lat = 0;
        req_hi_cnt = 0;
        do_req(1'b1, 32'h300, 1'b0, 32'h0, 3'b000, t_d, r_d);
        check("t4_busy_cycles", req_hi_cnt, TMO);
        check("t4_err_data", r_d, 32'hDEAD_BEEF);
        check("t4_bus_err", bus_err, 1'b1);
        be_lat = 1;
        do_req(1'b0, 32'h1100, 1'b0, 32'h0, 3'b010, t_i, r_i);
        check("t4_good_after_err", r_i, rd_word(32'h1100));
        check("t4_bus_err_sticky", bus_err, 1'b1);

        // T5: reset in the middle of a data access
        repeat (2) @(posedge clk); #1;
        be_lat = 5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; d_ubhw = 3'b100;
        repeat (3) @(negedge clk);
        check("t5_busy_before_rst", mem_req, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        d_ack_cnt = 0;
        #1;
        check("t5_async_mem_req", mem_req, 1'b0);
        check("t5_async_stall_mem", stall_mem, 1'b0);
        check("t5_async_state", dbg_state, 2'd0);
        check("t5_async_bus_err", bus_err, 1'b0);
        d_req = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_no_d_ack", d_ack_cnt, 0);
        @(posedge clk); #1;
        be_lat = 1;
        do_req(1'b1, 32'h704, 1'b0, 32'h0, 3'b010, t_d, r_d);
        check("t5_fresh_load", r_d, rd_word(32'h704));

        // T6: request inputs change while busy
        repeat (2) @(posedge clk); #1;
        be_lat = 3;
        fork
            do_req(1'b1, 32'h500, 1'b0, 32'h0, 3'b010, t_d, r_d);
            begin
                repeat (2) @(negedge clk);
                @(posedge clk); #1;
                d_addr = 32'h600;
                @(negedge clk);
                check("t6_addr_hold_c2", mem_addr, 32'h500);
                @(negedge clk);
                check("t6_addr_hold_c3", mem_addr, 32'h500);
            end
        join
        check("t6_load_data", r_d, rd_word(32'h500));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
